// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: FSM state codes, ALU opcodes and the supported-opcode predicate
package alu_arbiter_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SUBN = 5;
  localparam int unsigned OP_AND2 = 6;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 10;
  function automatic logic op_ok(input int unsigned op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SUBN, OP_AND2, OP_SLL, OP_SRL};
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU producing result, {v,z,c,s} flags and an unsupported-opcode error
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             err_o
);
  int unsigned opn;
  logic [WIDTH:0] sum;
  logic v;
  assign opn = 32'(op_i);
  // sum[WIDTH] is the carry for ADD and the borrow for SUB/SUBN
  always_comb begin
    sum = '0;
    v = 1'b0;
    case (opn)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUBN: begin
        sum = {1'b0, b_i} - {1'b0, a_i};
        v = (b_i[WIDTH-1] != a_i[WIDTH-1]) && (sum[WIDTH-1] != b_i[WIDTH-1]);
      end
      OP_AND:  sum = {1'b0, a_i & b_i};
      OP_OR:   sum = {1'b0, a_i | b_i};
      OP_XOR:  sum = {1'b0, a_i ^ b_i};
      OP_AND2: sum = {1'b0, a_i & ~b_i};
      OP_SLL:  sum = {1'b0, a_i << b_i};
      OP_SRL:  sum = {1'b0, a_i >> b_i};
      default: sum = '0;
    endcase
  end
  assign result_o = sum[WIDTH-1:0];
  assign flags_o = {v, ~|result_o, sum[WIDTH], result_o[WIDTH-1]};
  assign err_o = !op_ok(opn);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end sharing one ALU, one operation in flight
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);
  logic [1:0] state_q, state_d;
  logic last_q, id_q, grant1, accept;
  logic [OPW-1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, alu_result, rsp_result_q;
  logic [3:0] alu_flags, rsp_flags_q;
  logic alu_err, rsp_err_q, rsp_id_q;
  // last_q=1 means requester 1 was served last, so requester 0 wins the next contention
  assign grant1 = req1_valid && (!req0_valid || !last_q);
  assign accept = (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = !rst && accept && !grant1;
  assign req1_ready = !rst && accept && grant1;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err = rsp_err_q;
  always_comb begin
    state_d = accept ? S_EXEC :
              (state_q == S_EXEC) ? S_RESP :
              (state_q == S_RESP && !rsp_ready) ? S_RESP : S_IDLE;
  end
  alu_arbiter_alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .a_i(a_q),
    .b_i(b_q),
    .op_i(op_q),
    .result_o(alu_result),
    .flags_o(alu_flags),
    .err_o(alu_err)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_id_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant1;
        id_q <= grant1;
        op_q <= grant1 ? req1_op : req0_op;
        a_q <= grant1 ? req1_a : req0_a;
        b_q <= grant1 ? req1_b : req0_b;
      end
      if (state_q == S_EXEC) begin
        rsp_id_q <= id_q;
        rsp_result_q <= alu_err ? '0 : alu_result;
        rsp_flags_q <= alu_flags;
        rsp_err_q <= alu_err;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus checked every cycle against a transaction-level model
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [3:0] req0_op = '0, req1_op = '0, rsp_flags;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, rsp_result;
  typedef struct {int op; int a; int b;} req_t;
  typedef struct {int id; int res; int fl; int err;} rsp_t;
  req_t q0[$], q1[$];
  rsp_t log_q[$];
  int n_chk = 0, n_fail = 0, ph = 0, last = 1, m_id = 0;
  logic [20:0] m_exp = '0;
  logic g0_s = 1'b0, g1_s = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {err, v, z, c, s, result} from plain integer arithmetic
  function automatic logic [20:0] ref_alu(input int op, input int a, input int b);
    int sa, sb, r, sr;
    bit c, v, err;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    r = 0; sr = 0; c = 0; v = 0; err = 0;
    case (op)
      0: begin r = a + b; c = r > 65535; sr = sa + sb; v = sr > 32767 || sr < -32768; end
      1: begin r = a - b; c = a < b; sr = sa - sb; v = sr > 32767 || sr < -32768; end
      5: begin r = b - a; c = b < a; sr = sb - sa; v = sr > 32767 || sr < -32768; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      6: r = a & ~b;
      8: r = b >= 16 ? 0 : a << b;
      10: r = b >= 16 ? 0 : a >> b;
      default: err = 1;
    endcase
    r = r & 65535;
    return {err, v, r == 0, c, r >= 32768, 16'(r)};
  endfunction

  always @(negedge clk) begin
    g0_s <= req0_ready;
    g1_s <= req1_ready;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      q0.delete(); q1.delete();
    end else begin
      if (g0_s && q0.size() > 0) q0.delete(0);
      if (g1_s && q1.size() > 0) q1.delete(0);
    end
    req0_valid = q0.size() > 0;
    req1_valid = q1.size() > 0;
    if (q0.size() > 0) begin req0_op = 4'(q0[0].op); req0_a = 16'(q0[0].a); req0_b = 16'(q0[0].b); end
    if (q1.size() > 0) begin req1_op = 4'(q1[0].op); req1_a = 16'(q1[0].a); req1_b = 16'(q1[0].b); end
  end

  // model: idle -> (grant) -> one busy cycle -> response held until taken
  always @(negedge clk) begin
    int g;
    if (rst) begin
      ph = 0; last = 1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_readies", {req0_ready, req1_ready}, 0);
    end else if (ph == 0) begin
      g = (req0_valid && req1_valid) ? 1 - last : req0_valid ? 0 : req1_valid ? 1 : -1;
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      if (g >= 0) begin
        m_exp = g == 0 ? ref_alu(int'(req0_op), int'(req0_a), int'(req0_b))
                       : ref_alu(int'(req1_op), int'(req1_a), int'(req1_b));
        m_id = g; last = g; ph = 1;
      end
    end else if (ph == 1) begin
      chk("exec_readies", {req0_ready, req1_ready}, 0);
      chk("exec_rsp_valid", rsp_valid, 0);
      ph = 2;
    end else begin
      chk("resp_valid", rsp_valid, 1);
      chk("resp_readies", {req0_ready, req1_ready}, 0);
      chk("resp_id", rsp_id, m_id);
      chk("resp_result", rsp_result, m_exp[20] ? 0 : m_exp[15:0]);
      chk("resp_flags", rsp_flags, m_exp[19:16]);
      chk("resp_err", rsp_err, m_exp[20]);
      if (rsp_ready) begin
        log_q.push_back('{m_id, int'(rsp_result), int'(rsp_flags), int'(rsp_err)});
        ph = 0;
      end
    end
  end

  task automatic wait_done(input int n);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (log_q.size() >= n && ph == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    chk("wait_done_timeout", k < 100, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] held_res;
    logic [3:0] held_fl;
    int k;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    q0.push_back('{0, 16'h0003, 16'h0004});
    wait_done(1);
    chk("add_id", log_q[0].id, 0);
    chk("add_res", log_q[0].res, 16'h0007);
    chk("add_z", log_q[0].fl[2], 0);

    do_reset();
    log_q.delete();
    @(negedge clk);
    q0.push_back('{1, 16'h0005, 16'h0005});
    q1.push_back('{3, 16'h00F0, 16'h000F});
    wait_done(2);
    chk("contend_first_id", log_q[0].id, 0);
    chk("sub_res", log_q[0].res, 0);
    chk("sub_flags", log_q[0].fl, 4'b0100);
    chk("or_id", log_q[1].id, 1);
    chk("or_res", log_q[1].res, 16'h00FF);

    log_q.delete();
    @(negedge clk);
    q0.push_back('{0, 16'hFFFF, 16'h0001});
    q0.push_back('{6, 16'hFF0F, 16'h00FF});
    q0.push_back('{10, 16'h8000, 16'd15});
    q1.push_back('{0, 16'h7FFF, 16'h0001});
    q1.push_back('{5, 16'h0003, 16'h0001});
    q1.push_back('{1, 16'h8000, 16'h0001});
    wait_done(6);
    for (int i = 0; i < 6; i++) chk($sformatf("alt_id%0d", i), log_q[i].id, i % 2);
    chk("add_carry_flags", log_q[0].fl, 4'b0110);
    chk("add_ovf_flags", log_q[1].fl, 4'b1001);
    chk("subn_res", log_q[3].res, 16'hFFFE);

    log_q.delete();
    @(negedge clk);
    q0.push_back('{4, 16'hF0F0, 16'h0FF0});
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    chk("stall_rsp_seen", rsp_valid, 1);
    held_res = rsp_result;
    held_fl = rsp_flags;
    q1.push_back('{2, 16'h0FF0, 16'h00FF});
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_res_stable", rsp_result, held_res);
      chk("stall_flags_stable", rsp_flags, held_fl);
      chk("stall_no_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done(2);
    chk("xor_res", log_q[0].res, 16'hFF00);
    chk("after_stall_id", log_q[1].id, 1);

    log_q.delete();
    @(negedge clk);
    q1.push_back('{9, 16'h1234, 16'h0005});
    q1.push_back('{8, 16'h0001, 16'h0004});
    wait_done(2);
    chk("op9_err", log_q[0].err, 1);
    chk("op9_res", log_q[0].res, 0);
    chk("sll_res", log_q[1].res, 16'h0010);
    chk("sll_err", log_q[1].err, 0);

    log_q.delete();
    @(negedge clk);
    q0.push_back('{0, 16'h0001, 16'h0001});
    for (k = 0; k < 20 && !req0_ready; k++) @(negedge clk);
    chk("pre_rst_grant", req0_ready, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rsp_id", rsp_id, 0);
    chk("async_rsp_result", rsp_result, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_readies", {req0_ready, req1_ready}, 0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_rsp_after_rst", log_q.size(), 0);
    q0.push_back('{0, 16'h0002, 16'h0002});
    q1.push_back('{0, 16'h0003, 16'h0003});
    wait_done(2);
    chk("post_rst_first_id", log_q[0].id, 0);
    chk("post_rst_res", log_q[0].res, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
